// File: rtl/dmi_req_sequencer.sv
// dmi_req_sequencer
//   Sequences DMI transactions between the JTAG DMI data register and the
//   debug module's request/response handshake. A DR update issues at most one
//   request. The request is held until the DM accepts it. The response is then
//   latched for the next DR capture. The sticky dmistat error (failed/busy) is
//   kept here, along with the dmireset / dmihardreset handling.
//
// Ports
//   dm_clk_i, dm_rst_ni        clock, async active-low reset
//   update_dr_i, capture_dr_i  DR update / capture pulses (dm_clk_i domain)
//   dr_op_i/addr_i/data_i      DR fields (op: 0 NOP, 1 READ, 2 WRITE, 3 rsvd)
//   dmireset_i                 pulse, clears sticky error
//   dmihardreset_i             pulse, aborts transaction and clears state
//   dmi_req_*                  request channel toward the DM
//   dmi_resp_*                 response channel from the DM
//   dmi_rst_no                 one-cycle active-low reset toward the DM
//   capture_op/addr/data_o     values loaded into the DR on capture
//   dmistat_o                  sticky error for dtmcs.dmistat
//   busy_o                     transaction in flight
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction; DR updates may issue a request
// REQ       | request valid, payload held until the DM raises ready
// WAIT_RESP | request accepted, response ready high until a response

module dmi_req_sequencer #(
   parameter int AddrWidth = 7,
   parameter int DataWidth = 32
) (
   input  logic                 dm_clk_i,
   input  logic                 dm_rst_ni,
   input  logic                 update_dr_i,
   input  logic                 capture_dr_i,
   input  logic [1:0]           dr_op_i,
   input  logic [AddrWidth-1:0] dr_addr_i,
   input  logic [DataWidth-1:0] dr_data_i,
   input  logic                 dmireset_i,
   input  logic                 dmihardreset_i,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [1:0]           dmi_req_op_o,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [DataWidth-1:0] dmi_req_data_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [DataWidth-1:0] dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_resp_i,
   output logic                 dmi_rst_no,
   output logic [1:0]           capture_op_o,
   output logic [AddrWidth-1:0] capture_addr_o,
   output logic [DataWidth-1:0] capture_data_o,
   output logic [1:0]           dmistat_o,
   output logic                 busy_o
);

   localparam logic [1:0] OP_READ     = 2'd1;
   localparam logic [1:0] OP_WRITE    = 2'd2;
   localparam logic [1:0] RESP_FAILED = 2'd2;
   localparam logic [1:0] RESP_BUSY   = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_RESP = 2'd2
   } state_e;

   state_e               state;
   logic [1:0]           req_op;
   logic [AddrWidth-1:0] req_addr;
   logic [DataWidth-1:0] req_data;
   logic [AddrWidth-1:0] cap_addr;
   logic [DataWidth-1:0] cap_data;
   logic [1:0]           dmistat;
   logic                 dmi_rst_q;

   logic [1:0] stat_clr;
   logic [1:0] stat_next;
   logic       busy_err;
   logic       resp_fire;
   logic       resp_err;
   logic       issue;

   // dmireset is applied before any new error or update in the same cycle,
   // so an update arriving together with the clear is accepted.
   always_comb begin
      stat_clr  = dmireset_i ? 2'd0 : dmistat;
      busy_err  = (state != IDLE) && (update_dr_i || capture_dr_i);
      resp_fire = (state == WAIT_RESP) && dmi_resp_valid_i;
      resp_err  = resp_fire &&
                  ((dmi_resp_resp_i == RESP_FAILED) || (dmi_resp_resp_i == RESP_BUSY));
      issue     = (state == IDLE) && update_dr_i && (stat_clr == 2'd0) &&
                  ((dr_op_i == OP_READ) || (dr_op_i == OP_WRITE));

      // First nonzero code wins; a pending error is never overwritten.
      stat_next = stat_clr;
      if (stat_clr == 2'd0) begin
         if (busy_err) begin
            stat_next = RESP_BUSY;
         end else if (resp_err) begin
            stat_next = dmi_resp_resp_i;
         end
      end
   end

   always_ff @(posedge dm_clk_i or negedge dm_rst_ni) begin
      if (!dm_rst_ni) begin
         state     <= IDLE;
         req_op    <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         cap_addr  <= '0;
         cap_data  <= '0;
         dmistat   <= '0;
         dmi_rst_q <= 1'b1;
      end else if (dmihardreset_i) begin
         state     <= IDLE;
         req_op    <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         cap_addr  <= '0;
         cap_data  <= '0;
         dmistat   <= '0;
         dmi_rst_q <= 1'b0;
      end else begin
         dmi_rst_q <= 1'b1;
         dmistat   <= stat_next;
         case (state)
            IDLE: begin
               if (issue) begin
                  req_op   <= dr_op_i;
                  req_addr <= dr_addr_i;
                  req_data <= dr_data_i;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (dmi_req_ready_i) begin
                  state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (resp_fire) begin
                  cap_addr <= req_addr;
                  // A write reports its own data back on the next capture.
                  cap_data <= (req_op == OP_READ) ? dmi_resp_data_i : req_data;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dmi_req_valid_o  = (state == REQ);
   assign dmi_resp_ready_o = (state == WAIT_RESP);
   assign dmi_req_op_o     = req_op;
   assign dmi_req_addr_o   = req_addr;
   assign dmi_req_data_o   = req_data;
   assign dmi_rst_no       = dmi_rst_q;
   assign capture_op_o     = (state == IDLE) ? dmistat : RESP_BUSY;
   assign capture_addr_o   = cap_addr;
   assign capture_data_o   = cap_data;
   assign dmistat_o        = dmistat;
   assign busy_o           = (state != IDLE);

endmodule

// File: tb/tb_dmi_req_sequencer.sv
module tb_dmi_req_sequencer;

   logic        clk;
   logic        rst_n;
   logic        update_dr, capture_dr;
   logic [1:0]  dr_op;
   logic [6:0]  dr_addr;
   logic [31:0] dr_data;
   logic        dmireset, dmihardreset;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [6:0]  req_addr;
   logic [31:0] req_data;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [1:0]  resp_resp;
   logic        dmi_rst_n;
   logic [1:0]  cap_op;
   logic [6:0]  cap_addr;
   logic [31:0] cap_data;
   logic [1:0]  dmistat;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   int hs0;

   dmi_req_sequencer #(.AddrWidth(7), .DataWidth(32)) dut (
      .dm_clk_i         (clk),
      .dm_rst_ni        (rst_n),
      .update_dr_i      (update_dr),
      .capture_dr_i     (capture_dr),
      .dr_op_i          (dr_op),
      .dr_addr_i        (dr_addr),
      .dr_data_i        (dr_data),
      .dmireset_i       (dmireset),
      .dmihardreset_i   (dmihardreset),
      .dmi_req_valid_o  (req_valid),
      .dmi_req_ready_i  (req_ready),
      .dmi_req_op_o     (req_op),
      .dmi_req_addr_o   (req_addr),
      .dmi_req_data_o   (req_data),
      .dmi_resp_valid_i (resp_valid),
      .dmi_resp_ready_o (resp_ready),
      .dmi_resp_data_i  (resp_data),
      .dmi_resp_resp_i  (resp_resp),
      .dmi_rst_no       (dmi_rst_n),
      .capture_op_o     (cap_op),
      .capture_addr_o   (cap_addr),
      .capture_data_o   (cap_data),
      .dmistat_o        (dmistat),
      .busy_o           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count accepted requests on the DMI bus.
   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready) hs_count++;
   end

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [1:0]  rcode;
      bit          exp_req;
      logic [6:0]  exp_addr;
      logic [31:0] exp_cdata;
      logic [1:0]  exp_stat;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
      update_dr = 1'b1;
      dr_op     = op;
      dr_addr   = addr;
      dr_data   = data;
      step();
      update_dr = 1'b0;
   endtask

   task automatic respond(input logic [31:0] rdata, input logic [1:0] rcode);
      resp_valid = 1'b1;
      resp_data  = rdata;
      resp_resp  = rcode;
      step();
      resp_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      req_ready = 1'b1;
      pulse_update(v.op, v.addr, v.data);
      if (v.exp_req) begin
         check($sformatf("v%0d valid", idx), {31'd0, req_valid}, 32'd1);
         check($sformatf("v%0d req_op", idx), {30'd0, req_op}, {30'd0, v.op});
         check($sformatf("v%0d req_addr", idx), {25'd0, req_addr}, {25'd0, v.addr});
         check($sformatf("v%0d req_data", idx), req_data, v.data);
         step();
         check($sformatf("v%0d resp_ready", idx), {31'd0, resp_ready}, 32'd1);
         check($sformatf("v%0d valid_drop", idx), {31'd0, req_valid}, 32'd0);
         respond(v.rdata, v.rcode);
      end else begin
         check($sformatf("v%0d no_valid", idx), {31'd0, req_valid}, 32'd0);
         step();
         check($sformatf("v%0d no_valid2", idx), {31'd0, req_valid}, 32'd0);
      end
      check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d cap_addr", idx), {25'd0, cap_addr}, {25'd0, v.exp_addr});
      check($sformatf("v%0d cap_data", idx), cap_data, v.exp_cdata);
      check($sformatf("v%0d dmistat", idx), {30'd0, dmistat}, {30'd0, v.exp_stat});
      check($sformatf("v%0d cap_op", idx), {30'd0, cap_op}, {30'd0, v.exp_stat});
   endtask

   initial begin
      vecs[0] = '{2'd2, 7'h10, 32'h0000_0001, 32'h0,          2'd0, 1'b1, 7'h10, 32'h0000_0001, 2'd0};
      vecs[1] = '{2'd1, 7'h11, 32'h0000_5555, 32'hCAFE_F00D,  2'd0, 1'b1, 7'h11, 32'hCAFE_F00D, 2'd0};
      vecs[2] = '{2'd0, 7'h22, 32'h0000_0077, 32'h0,          2'd0, 1'b0, 7'h11, 32'hCAFE_F00D, 2'd0};
      vecs[3] = '{2'd3, 7'h33, 32'h0000_0088, 32'h0,          2'd0, 1'b0, 7'h11, 32'hCAFE_F00D, 2'd0};
      vecs[4] = '{2'd2, 7'h7F, 32'hFFFF_FFFF, 32'h1234_5678,  2'd0, 1'b1, 7'h7F, 32'hFFFF_FFFF, 2'd0};
      vecs[5] = '{2'd1, 7'h01, 32'h0000_0000, 32'hA5A5_A5A5,  2'd0, 1'b1, 7'h01, 32'hA5A5_A5A5, 2'd0};

      rst_n = 1'b0; update_dr = 1'b0; capture_dr = 1'b0; dr_op = 2'd0;
      dr_addr = '0; dr_data = '0; dmireset = 1'b0; dmihardreset = 1'b0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_resp = 2'd0;
      step();
      step();
      check("rst valid", {31'd0, req_valid}, 32'd0);
      check("rst resp_ready", {31'd0, resp_ready}, 32'd0);
      check("rst req_op", {30'd0, req_op}, 32'd0);
      check("rst req_addr", {25'd0, req_addr}, 32'd0);
      check("rst req_data", req_data, 32'd0);
      check("rst cap_op", {30'd0, cap_op}, 32'd0);
      check("rst cap_addr", {25'd0, cap_addr}, 32'd0);
      check("rst cap_data", cap_data, 32'd0);
      check("rst dmistat", {30'd0, dmistat}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst dmi_rst_n", {31'd0, dmi_rst_n}, 32'd1);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Read with back-pressure: ready low for 5 cycles, valid held 6 cycles.
      req_ready = 1'b0;
      pulse_update(2'd1, 7'h11, 32'h0BAD_F00D);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp valid c%0d", i), {31'd0, req_valid}, 32'd1);
         check($sformatf("bp addr c%0d", i), {25'd0, req_addr}, 32'h11);
         check($sformatf("bp op c%0d", i), {30'd0, req_op}, 32'd1);
         check($sformatf("bp data c%0d", i), req_data, 32'h0BAD_F00D);
         req_ready = (i == 5);
         step();
      end
      req_ready = 1'b0;
      check("bp valid_drop", {31'd0, req_valid}, 32'd0);
      check("bp resp_ready", {31'd0, resp_ready}, 32'd1);
      respond(32'hDEAD_BEEF, 2'd0);
      check("bp cap_data", cap_data, 32'hDEAD_BEEF);
      check("bp cap_addr", {25'd0, cap_addr}, 32'h11);
      check("bp dmistat", {30'd0, dmistat}, 32'd0);
      check("bp busy", {31'd0, busy}, 32'd0);

      // Busy: update and capture during a delayed response.
      hs0 = hs_count;
      req_ready = 1'b1;
      pulse_update(2'd1, 7'h12, 32'h0);
      step();
      req_ready = 1'b0;
      check("busy in_wait", {31'd0, resp_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         update_dr  = (i == 1);
         dr_op      = 2'd2;
         dr_addr    = 7'h55;
         dr_data    = 32'h5555_5555;
         dmireset   = (i == 3);
         capture_dr = (i == 5);
         step();
         update_dr = 1'b0; dmireset = 1'b0; capture_dr = 1'b0;
         if (i == 1) begin
            check("busy upd dmistat", {30'd0, dmistat}, 32'd3);
            check("busy upd cap_op", {30'd0, cap_op}, 32'd3);
         end
         if (i == 3) begin
            check("busy clr dmistat", {30'd0, dmistat}, 32'd0);
            check("busy clr still busy", {31'd0, busy}, 32'd1);
         end
         if (i == 5) check("busy cap dmistat", {30'd0, dmistat}, 32'd3);
      end
      respond(32'h1111_2222, 2'd0);
      check("busy done", {31'd0, busy}, 32'd0);
      check("busy cap_addr", {25'd0, cap_addr}, 32'h12);
      check("busy cap_data", cap_data, 32'h1111_2222);
      check("busy sticky", {30'd0, dmistat}, 32'd3);
      check("busy idle cap_op", {30'd0, cap_op}, 32'd3);
      check("busy one req", hs_count - hs0, 32'd1);
      req_ready = 1'b1;
      pulse_update(2'd2, 7'h20, 32'h0000_0099);
      check("busy ignored valid", {31'd0, req_valid}, 32'd0);
      check("busy ignored busy", {31'd0, busy}, 32'd0);
      step();
      check("busy ignored count", hs_count - hs0, 32'd1);
      dmireset = 1'b1;
      step();
      dmireset = 1'b0;
      check("busy reset dmistat", {30'd0, dmistat}, 32'd0);
      pulse_update(2'd2, 7'h20, 32'h0000_0099);
      check("busy reissue valid", {31'd0, req_valid}, 32'd1);
      check("busy reissue addr", {25'd0, req_addr}, 32'h20);
      step();
      respond(32'h0, 2'd0);
      check("busy reissue count", hs_count - hs0, 32'd2);
      check("busy reissue cap_data", cap_data, 32'h0000_0099);

      // Failed response, then sticky behaviour.
      req_ready = 1'b1;
      pulse_update(2'd1, 7'h13, 32'h0);
      step();
      respond(32'h0, 2'd2);
      check("fail dmistat", {30'd0, dmistat}, 32'd2);
      check("fail cap_op", {30'd0, cap_op}, 32'd2);
      pulse_update(2'd1, 7'h14, 32'h0);
      check("fail ignored valid", {31'd0, req_valid}, 32'd0);
      check("fail ignored stat", {30'd0, dmistat}, 32'd2);
      dmireset = 1'b1;
      pulse_update(2'd1, 7'h14, 32'h0);
      dmireset = 1'b0;
      check("fail rst+upd valid", {31'd0, req_valid}, 32'd1);
      check("fail rst+upd addr", {25'd0, req_addr}, 32'h14);
      check("fail rst+upd stat", {30'd0, dmistat}, 32'd0);
      req_ready = 1'b0;
      pulse_update(2'd2, 7'h66, 32'h0);
      check("fail busy stat", {30'd0, dmistat}, 32'd3);
      check("fail held addr", {25'd0, req_addr}, 32'h14);
      req_ready = 1'b1;
      step();
      respond(32'h0000_3C3C, 2'd2);
      check("fail first kept", {30'd0, dmistat}, 32'd3);
      check("fail cap_data", cap_data, 32'h0000_3C3C);
      check("fail cap_addr", {25'd0, cap_addr}, 32'h14);
      dmireset = 1'b1;
      step();
      dmireset = 1'b0;
      check("fail cleared", {30'd0, dmistat}, 32'd0);

      // Hard reset while a request is pending.
      hs0 = hs_count;
      req_ready = 1'b0;
      pulse_update(2'd2, 7'h30, 32'h0000_005A);
      check("hard valid", {31'd0, req_valid}, 32'd1);
      capture_dr = 1'b1;
      step();
      capture_dr = 1'b0;
      check("hard pre stat", {30'd0, dmistat}, 32'd3);
      dmihardreset = 1'b1;
      pulse_update(2'd1, 7'h31, 32'h0);
      dmihardreset = 1'b0;
      check("hard valid_drop", {31'd0, req_valid}, 32'd0);
      check("hard busy", {31'd0, busy}, 32'd0);
      check("hard dmistat", {30'd0, dmistat}, 32'd0);
      check("hard rst_n low", {31'd0, dmi_rst_n}, 32'd0);
      check("hard cap_addr", {25'd0, cap_addr}, 32'd0);
      check("hard cap_data", cap_data, 32'd0);
      check("hard cap_op", {30'd0, cap_op}, 32'd0);
      step();
      check("hard rst_n high", {31'd0, dmi_rst_n}, 32'd1);
      check("hard upd dropped", {31'd0, req_valid}, 32'd0);
      check("hard no req", hs_count - hs0, 32'd0);

      // Asynchronous reset mid-transaction.
      pulse_update(2'd1, 7'h40, 32'h0);
      check("async pre valid", {31'd0, req_valid}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async valid", {31'd0, req_valid}, 32'd0);
      check("async busy", {31'd0, busy}, 32'd0);
      check("async req_addr", {25'd0, req_addr}, 32'd0);
      check("async dmi_rst_n", {31'd0, dmi_rst_n}, 32'd1);
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
